// File: rtl/gb_video_pkg.sv
// Shared constants and types for the Game Boy LCD video path.
// Geometry is common to the LCD generator and the frame blender.
package gb_video_pkg;

    localparam int GB_H_ACTIVE = 320;
    localparam int GB_V_ACTIVE = 144;
    localparam int GB_CBITS    = 6;
    localparam int GB_FS_DEPTH = GB_H_ACTIVE * GB_V_ACTIVE;

    typedef enum logic [1:0] {
        BLEND_OFF     = 2'd0,
        BLEND_HALF    = 2'd1,
        BLEND_QUARTER = 2'd2
    } blend_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_MIX  = 2'd2
    } fb_state_t;

    // Truncating blend; mode 0 and the unused code 3 pass c through.
    function automatic logic [7:0] blend_px(
        input logic [1:0] mode,
        input logic [7:0] c,
        input logic [7:0] p
    );
        logic [8:0] s_half;
        logic [9:0] s_qtr;
        logic [7:0] res;
        s_half = {1'b0, c} + {1'b0, p};
        s_qtr  = {1'b0, c, 1'b0} + {2'b00, c} + {2'b00, p};
        res    = c;
        unique case (1'b1)
            (mode == BLEND_HALF):    res = s_half[8:1];
            (mode == BLEND_QUARTER): res = s_qtr[9:2];
            default:                 res = c;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/gb_frame_blend_if.sv
// Pixel-stream bundle between LCD generator, blender and scaler.
// master drives the stream, slave consumes it.
interface gb_frame_blend_if;

    logic       ce_pix;
    logic       hs;
    logic       vs;
    logic       hbl;
    logic       vbl;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (
        output ce_pix, hs, vs, hbl, vbl, r, g, b
    );

    modport slave (
        input ce_pix, hs, vs, hbl, vbl, r, g, b
    );

endinterface

// File: rtl/gb_frame_store.sv
// Single-port read-first frame store; no reset so it maps onto BRAM.
// Read data appears the cycle after an enabled access.
module gb_frame_store #(
    parameter int DEPTH = 46080,
    parameter int WIDTH = 18,
    parameter int AW    = 16
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/gb_frame_blend.sv
// LCD persistence blender: mixes each pixel with the previous frame's
// co-located pixel and re-emits the stream one ce_pix later.
module gb_frame_blend
    import gb_video_pkg::*;
#(
    parameter int H_ACTIVE = GB_H_ACTIVE,
    parameter int V_ACTIVE = GB_V_ACTIVE,
    parameter int CBITS    = GB_CBITS
) (
    input  logic             clk_vid,
    input  logic             reset_n,
    input  logic [1:0]       blend_mode,
    gb_frame_blend_if.slave  i_vid,
    gb_frame_blend_if.master o_vid,
    output logic             frame_valid
);

    localparam int LIMIT = H_ACTIVE * V_ACTIVE;
    localparam int CNW   = $clog2(LIMIT + 1);
    localparam int AW    = $clog2(LIMIT);
    localparam int WW    = 3 * CBITS;
    localparam logic [CNW-1:0] LIM_C = CNW'(LIMIT);

    fb_state_t r_state;
    fb_state_t w_state_nx;

    logic [CNW-1:0] r_addr;
    logic [CNW-1:0] r_cur_addr;
    logic           r_ovf;
    logic           r_vbl_q;
    logic           r_fv;
    logic           r_acc;
    logic [1:0]     r_mode;
    logic [7:0]     r_cur_r, r_cur_g, r_cur_b;
    logic           r_hs_d, r_vs_d, r_hbl_d, r_vbl_d;
    logic [7:0]     r_hold_r, r_hold_g, r_hold_b;
    logic           r_o_hs, r_o_vs, r_o_hbl, r_o_vbl;
    logic [7:0]     r_o_r, r_o_g, r_o_b;
    logic           r_ce_q;

    logic           w_ce;
    logic           w_active;
    logic           w_in_range;
    logic           w_vbl_rise;
    logic           w_bypass;
    logic           w_ram_en;
    logic           w_ram_we;
    logic [AW-1:0]  w_ram_addr;
    logic [WW-1:0]  w_ram_wdata;
    logic [WW-1:0]  w_ram_rdata;
    logic [CBITS-1:0]   w_rd_r, w_rd_g, w_rd_b;
    logic [2*CBITS-1:0] w_x_r, w_x_g, w_x_b;
    logic [7:0]     w_p_r, w_p_g, w_p_b;

    // A pulse outside IDLE is dropped entirely, not queued.
    assign w_ce       = i_vid.ce_pix && (r_state == ST_IDLE);
    assign w_active   = !i_vid.hbl && !i_vid.vbl;
    assign w_in_range = (r_addr < LIM_C);
    assign w_vbl_rise = i_vid.vbl && !r_vbl_q;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ram_en   = 1'b0;
        w_ram_we   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ce) begin
                    w_state_nx = (w_active && w_in_range) ? ST_RD : ST_MIX;
                end
            end
            ST_RD: begin
                w_ram_en   = 1'b1;
                w_state_nx = ST_MIX;
            end
            ST_MIX: begin
                w_ram_en   = r_acc;
                w_ram_we   = r_acc;
                w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_cur_addr <= '0;
            r_ovf      <= 1'b0;
            r_vbl_q    <= 1'b1;
            r_fv       <= 1'b0;
            r_acc      <= 1'b0;
            r_mode     <= 2'd0;
            r_cur_r    <= 8'd0;
            r_cur_g    <= 8'd0;
            r_cur_b    <= 8'd0;
            r_hs_d     <= 1'b0;
            r_vs_d     <= 1'b0;
            r_hbl_d    <= 1'b1;
            r_vbl_d    <= 1'b1;
            r_o_hs     <= 1'b0;
            r_o_vs     <= 1'b0;
            r_o_hbl    <= 1'b1;
            r_o_vbl    <= 1'b1;
            r_o_r      <= 8'd0;
            r_o_g      <= 8'd0;
            r_o_b      <= 8'd0;
        end else if (w_ce) begin
            r_vbl_q    <= i_vid.vbl;
            r_cur_addr <= r_addr;
            r_acc      <= w_active && w_in_range;
            r_mode     <= blend_mode;
            r_cur_r    <= i_vid.r;
            r_cur_g    <= i_vid.g;
            r_cur_b    <= i_vid.b;
            r_hs_d     <= i_vid.hs;
            r_vs_d     <= i_vid.vs;
            r_hbl_d    <= i_vid.hbl;
            r_vbl_d    <= i_vid.vbl;
            r_o_hs     <= r_hs_d;
            r_o_vs     <= r_vs_d;
            r_o_hbl    <= r_hbl_d;
            r_o_vbl    <= r_vbl_d;
            r_o_r      <= r_hold_r;
            r_o_g      <= r_hold_g;
            r_o_b      <= r_hold_b;
            // Frame is trusted only if it filled the store exactly.
            if (w_vbl_rise) begin
                r_fv   <= (r_addr == LIM_C) && !r_ovf;
                r_addr <= '0;
                r_ovf  <= 1'b0;
            end else if (w_active) begin
                if (w_in_range) begin
                    r_addr <= r_addr + 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_ce_q <= 1'b0;
        end else begin
            r_ce_q <= w_ce;
        end
    end

    assign w_rd_r = w_ram_rdata[WW-1 -: CBITS];
    assign w_rd_g = w_ram_rdata[2*CBITS-1 -: CBITS];
    assign w_rd_b = w_ram_rdata[CBITS-1:0];

    // Widen stored channels back to 8 bits by repeating their MSBs.
    assign w_x_r = {w_rd_r, w_rd_r};
    assign w_x_g = {w_rd_g, w_rd_g};
    assign w_x_b = {w_rd_b, w_rd_b};
    assign w_p_r = w_x_r[2*CBITS-1 -: 8];
    assign w_p_g = w_x_g[2*CBITS-1 -: 8];
    assign w_p_b = w_x_b[2*CBITS-1 -: 8];

    assign w_bypass = !r_acc || !r_fv;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_r <= 8'd0;
            r_hold_g <= 8'd0;
            r_hold_b <= 8'd0;
        end else if (r_state == ST_MIX) begin
            if (w_bypass) begin
                r_hold_r <= r_cur_r;
                r_hold_g <= r_cur_g;
                r_hold_b <= r_cur_b;
            end else begin
                r_hold_r <= blend_px(r_mode, r_cur_r, w_p_r);
                r_hold_g <= blend_px(r_mode, r_cur_g, w_p_g);
                r_hold_b <= blend_px(r_mode, r_cur_b, w_p_b);
            end
        end
    end

    assign w_ram_addr  = r_cur_addr[AW-1:0];
    assign w_ram_wdata = {r_cur_r[7 -: CBITS],
                          r_cur_g[7 -: CBITS],
                          r_cur_b[7 -: CBITS]};

    gb_frame_store #(
        .DEPTH (LIMIT),
        .WIDTH (WW),
        .AW    (AW)
    ) u_store (
        .i_clk   (clk_vid),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign o_vid.ce_pix = r_ce_q;
    assign o_vid.hs     = r_o_hs;
    assign o_vid.vs     = r_o_vs;
    assign o_vid.hbl    = r_o_hbl;
    assign o_vid.vbl    = r_o_vbl;
    assign o_vid.r      = r_o_r;
    assign o_vid.g      = r_o_g;
    assign o_vid.b      = r_o_b;
    assign frame_valid  = r_fv;

    a_ce_idle: assert property (@(posedge clk_vid) disable iff (!reset_n)
        i_vid.ce_pix |-> (r_state == ST_IDLE));

endmodule

// File: tb/tb_gb_frame_blend.sv
// Directed bench for gb_frame_blend on a reduced 4x3 geometry.
// Expected pixels come from a reference model queued at drive time.
module tb_gb_frame_blend;

    import gb_video_pkg::*;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int LIM = H * V;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       hbl;
        logic       vbl;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } px_t;

    localparam px_t RST_PX = px_t'({4'b0011, 24'h000000});

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic       fv;

    gb_frame_blend_if vin ();
    gb_frame_blend_if vout ();

    gb_frame_blend #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .CBITS    (6)
    ) dut (
        .clk_vid     (clk),
        .reset_n     (rst_n),
        .blend_mode  (mode),
        .i_vid       (vin),
        .o_vid       (vout),
        .frame_valid (fv)
    );

    always #5 clk = ~clk;

    px_t        q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    string      phase   = "init";
    int         m_cnt;
    bit         m_fv, m_ovf, m_vq;
    logic [5:0] m_r [LIM];
    logic [5:0] m_g [LIM];
    logic [5:0] m_b [LIM];
    logic [7:0] la_r, la_g, la_b;

    function automatic logic [7:0] exp8(input logic [5:0] s);
        return {s, s[5:4]};
    endfunction

    function automatic logic [7:0] mix(input int md, input logic [7:0] c, input logic [7:0] p);
        int v;
        if (md == 1)      v = (int'(c) + int'(p)) / 2;
        else if (md == 2) v = (3 * int'(c) + int'(p)) / 4;
        else              v = int'(c);
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_fv  = 1'b0;
        m_ovf = 1'b0;
        m_vq  = 1'b1;
        q.delete();
        q.push_back(RST_PX);
    endtask

    task automatic send_pix(input logic hs, input logic vs, input logic hbl, input logic vbl,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        px_t e, o;
        bit  act;
        @(negedge clk);
        vin.hs = hs; vin.vs = vs; vin.hbl = hbl; vin.vbl = vbl;
        vin.r = r; vin.g = g; vin.b = b;
        vin.ce_pix = 1'b1;
        e   = {hs, vs, hbl, vbl, r, g, b};
        act = !hbl && !vbl;
        if (vbl && !m_vq) begin
            m_fv  = (m_cnt == LIM) && !m_ovf;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (act) begin
            if (m_cnt < LIM) begin
                if (m_fv) begin
                    e.r = mix(int'(mode), r, exp8(m_r[m_cnt]));
                    e.g = mix(int'(mode), g, exp8(m_g[m_cnt]));
                    e.b = mix(int'(mode), b, exp8(m_b[m_cnt]));
                end
                m_r[m_cnt] = r[7:2];
                m_g[m_cnt] = g[7:2];
                m_b[m_cnt] = b[7:2];
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_vq = vbl;
        @(posedge clk);
        #1;
        vin.ce_pix = 1'b0;
        o = {vout.hs, vout.vs, vout.hbl, vout.vbl, vout.r, vout.g, vout.b};
        if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s/scoreboard: got %0h expected queued entry", phase, o);
        end else begin
            chk("pixel", 64'(o), 64'(q.pop_front()));
        end
        chk("frame_valid", 64'(fv), 64'(m_fv));
        if (!o.hbl && !o.vbl) begin
            la_r = o.r; la_g = o.g; la_b = o.b;
        end
        q.push_back(e);
        repeat (3) @(posedge clk);
    endtask

    task automatic run_frame(input int lines, input logic [7:0] rr,
                             input logic [7:0] gg, input logic [7:0] bb);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < H; p++) send_pix(1'b0, 1'b0, 1'b0, 1'b0, rr, gg, bb);
            send_pix(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        end
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p <= H; p++) begin
                send_pix(p == H, l == 0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode  = BLEND_OFF;
        vin.ce_pix = 1'b0;
        vin.hs = 1'b0; vin.vs = 1'b0; vin.hbl = 1'b1; vin.vbl = 1'b1;
        vin.r = 8'h00; vin.g = 8'h00; vin.b = 8'h00;
        la_r = 8'h00; la_g = 8'h00; la_b = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        phase = "reset";
        chk("outputs", 64'({vout.hs, vout.vs, vout.hbl, vout.vbl, vout.r, vout.g, vout.b}), 64'(RST_PX));
        chk("fv", 64'(fv), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "f1_first";
        mode = BLEND_HALF;
        run_frame(V, 8'hFF, 8'h80, 8'h10);
        chk("r_bypass", 64'(la_r), 64'h0FF);
        chk("fv_set", 64'(fv), 64'd1);

        phase = "f2_half";
        run_frame(V, 8'h00, 8'h40, 8'h20);
        chk("r", 64'(la_r), 64'h07F);
        chk("g", 64'(la_g), 64'h061);
        chk("b", 64'(la_b), 64'h018);

        phase = "f3_mode3";
        mode = 2'd3;
        run_frame(V, 8'hFF, 8'h80, 8'h10);
        chk("r_bypass", 64'(la_r), 64'h0FF);

        phase = "f4_quarter";
        mode = BLEND_QUARTER;
        run_frame(V, 8'h00, 8'h40, 8'h20);
        chk("r", 64'(la_r), 64'h03F);
        chk("g", 64'(la_g), 64'h050);

        phase = "f5_short";
        mode = BLEND_HALF;
        run_frame(V - 1, 8'hAA, 8'hAA, 8'hAA);
        chk("fv_drop", 64'(fv), 64'd0);

        phase = "f6_recover";
        run_frame(V, 8'h55, 8'h55, 8'h55);
        chk("r_bypass", 64'(la_r), 64'h055);
        chk("fv_set", 64'(fv), 64'd1);

        phase = "f7_long";
        mode = BLEND_OFF;
        run_frame(V + 1, 8'h11, 8'h11, 8'h11);
        chk("fv_drop", 64'(fv), 64'd0);

        phase = "f8_full";
        mode = BLEND_HALF;
        run_frame(V, 8'hFF, 8'hFF, 8'hFF);
        chk("fv_set", 64'(fv), 64'd1);

        phase = "f9_midreset";
        send_pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 8'h77, 8'h77);
        send_pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 8'h77, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out", 64'({vout.hs, vout.vs, vout.hbl, vout.vbl, vout.r, vout.g, vout.b}), 64'(RST_PX));
        chk("async_fv", 64'(fv), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        phase = "f10_after_reset";
        run_frame(V, 8'h33, 8'h33, 8'h33);
        chk("r_bypass", 64'(la_r), 64'h033);
        chk("fv_set", 64'(fv), 64'd1);

        phase = "f11_blend";
        run_frame(V, 8'h00, 8'h00, 8'h00);
        chk("r", 64'(la_r), 64'h018);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_frame_blend.md
Name: gb_frame_blend

Overview:
- Downstream stage of the LCD video generator, in the clk_vid domain.
- Takes the generator's pixel stream (ce_pix, hs, vs, hbl, vbl, r, g, b) and stores each active pixel of a frame in a frame store.
- Blends each pixel with the co-located pixel of the previous frame to emulate DMG/GBC LCD persistence and remove 30 Hz flicker.
- Output has the same timing, delayed by exactly one ce_pix, and feeds the scaler/OSD path.

Parameters:
- H_ACTIVE, 320, active pixels per line (two 160-pixel cores side by side).
- V_ACTIVE, 144, active lines per frame.
- CBITS, 6, stored bits per colour channel (frame store width = 3*CBITS).

Ports:
- clk_vid  in  1  video clock, 67.108864 MHz.
- reset_n  in  1  asynchronous active-low reset.
- ce_pix  in  1  pixel enable, one clk_vid pulse; consecutive pulses are ≥4 clk_vid apart.
- hs_in, vs_in, hbl_in, vbl_in  in  1 each  timing from the LCD generator.
- r_in, g_in, b_in  in  8 each  pixel colour.
- blend_mode  in  2  0=bypass, 1=50/50, 2=75% current/25% previous, 3=bypass.
- hs, vs, hbl, vbl  out  1 each  delayed timing.
- r, g, b  out  8 each  blended colour.
- frame_valid  out  1  store holds a complete, geometry-consistent previous frame.

Behaviour:
- Clock and reset: one clock, clk_vid. reset_n is asynchronous, active-low.
- Reset values: r = g = b = 0, hs = vs = 0, hbl = vbl = 1, frame_valid = 0, address = 0, FSM = IDLE. Frame store contents are not reset.
- Active pixel: ce_pix & ~hbl_in & ~vbl_in.
- Address counter (16 bit):
  - Increments after each active pixel.
  - Cleared on the vbl_in rising edge, sampled at ce_pix.
  - Saturates at H_ACTIVE*V_ACTIVE. No read or write occurs at the saturated value.
- FSM states IDLE → RD → MIX → IDLE:
  - IDLE: on ce_pix, latch inputs and the address; go to RD if active and address < limit, otherwise to MIX with the previous value forced to the current pixel.
  - RD: present the read address to the store; read-first data is available next cycle.
  - MIX: compute the blend into the out_hold registers. Write the current un-blended pixel, truncated to the top CBITS of each channel, at the same address.
  - Return to IDLE. The sequence completes within 3 clk_vid, inside the ce_pix spacing.
- ce_pix arriving outside IDLE is a protocol violation: it is ignored and a simulation assertion fires.
- Output: on each ce_pix, out_hold plus the delayed hs/vs/hbl/vbl move to the outputs. Latency is exactly one ce_pix; the output changes on the same clk_vid edge as the next input is sampled.
- Arithmetic, per channel:
  - p = {prev[CBITS-1:0], prev[CBITS-1:CBITS-8+CBITS]} (stored value expanded to 8 bits by replicating its top bits).
  - Mode 1: (c + p) >> 1, 9-bit sum.
  - Mode 2: (3c + p) >> 2, 10-bit sum.
  - No rounding, no saturation needed.
- Bypass: mode 0, mode 3, or frame_valid = 0 output c unchanged. The store is still written in every mode, so enabling blend takes effect on the next frame.
- frame_valid, evaluated at the vbl_in rising edge:
  - Set if exactly H_ACTIVE*V_ACTIVE active pixels were seen this frame.
  - Cleared otherwise (short frame, or saturation reached with extra pixels pending).
- Blanking pixels: output c unchanged; blanking is typically 0.
- Mid-frame reset: everything returns to reset values; frame_valid = 0, so the first frame after reset passes through unchanged.
- Mode change mid-frame takes effect on the next active pixel.

Decomposition:
- Shared package gb_video_pkg:
  - GB_H_ACTIVE and GB_V_ACTIVE constants, shared with the LCD generator.
  - blend_mode_t enum: BLEND_OFF, BLEND_HALF, BLEND_QUARTER.
  - Frame-store depth constant.
- One sub-module, gb_frame_store: single-port synchronous RAM, depth H_ACTIVE*V_ACTIVE, width 3*CBITS, read-first, infers BRAM, no reset.

Test Plan:
- Reset, then frame 1 with r=0xFF in mode 1 → output equals input (frame_valid = 0); frame_valid = 1 after the vbl rise.
- Frame 2 with r=0x00, mode 1, previous 0xFF → r out = 0x7F. Mode 2 → r out = 0x3F.
- Previous g=0x80 (stored 0x20, expanded 0x82), current g=0x40, mode 1 → g out = 0x61.
- Short frame of 143 lines → frame_valid drops at vbl. Next frame outputs bypass; the following full frame restores frame_valid.
- Latency check: pixel sampled at ce_pix k appears at the outputs at ce_pix k+1; hbl/vbl/hs/vs are delayed identically.
- Assert reset_n low mid-line → outputs go to reset values asynchronously; the first frame after release passes through unchanged.
